bcd_down_timer: RTL and testbench

// Multi-digit synchronous BCD down-counter (countdown timer); reverse direction of bcd_counter.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_dec.sv | 28 ++
 rtl/bcd_down_timer.sv | 139 +++++++++++++
 tb/tb_bcd_down_timer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer.
//   BCD_W / BCD_MAX : width of one BCD digit and its largest legal value
//   bcd_t           : one packed BCD digit
//   tmr_state_t     : timer FSM states (IDLE, RUN, HOLD)
//   is_bcd()        : 1 when a nibble is a legal BCD digit (0..9)
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } tmr_state_t;

  function automatic logic is_bcd(bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement stage.
//   d          : current digit (0..9)
//   borrow_in  : 1 = subtract one from this digit
//   d_next     : resulting digit
//   borrow_out : 1 when this digit wrapped 0 -> 9 and the next digit must be decremented
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       borrow_in,
  output logic [3:0] d_next,
  output logic       borrow_out
);

  always_comb begin
    d_next     = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == 4'd0) begin
        d_next     = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        d_next = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer. Loads a packed BCD preset, then decrements
// once per prescaled tick until zero, pulsing done on arrival.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   load       : load load_val (highest priority; rejected if any digit > 9)
//   load_val   : packed BCD preset, digit 0 in bits [3:0]
//   start      : begin counting from IDLE (q != 0) or resume from HOLD
//   pause      : freeze counting while in RUN
//   q          : registered packed BCD count
//   running    : 1 while in RUN
//   zero       : q == 0
//   done       : one-cycle pulse in the cycle q first shows 0 after a run
//   load_err   : one-cycle pulse after a rejected load
//   state_dbg  : current FSM state encoding (IDLE=0, RUN=1, HOLD=2)
//
// Control inputs are level-sampled on every rising edge; there is no
// handshake, a command takes effect on the edge at which it is seen high.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] q,
  output logic                running,
  output logic                zero,
  output logic                done,
  output logic                load_err,
  output logic [1:0]          state_dbg
);

  localparam int             QW      = 4 * DIGITS;
  localparam int             PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  tmr_state_t    state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [QW-1:0] q_next, q_dec;
  logic          done_next, load_err_next;
  logic          load_ok;
  logic          tick;
  logic [DIGITS:0] borrow;

  // Borrow chain LSD -> MSD; the LSD always receives a borrow so q_dec is q-1.
  // A borrow out of the MSD means q was already zero, which blocks any wrap.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_dec u_dec (
      .d          (q[i*4 +: 4]),
      .borrow_in  (borrow[i]),
      .d_next     (q_dec[i*4 +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[i*4 +: 4])) load_ok = 1'b0;
    end
  end

  assign tick      = (presc == PS_LAST);
  assign zero      = (q == '0);
  assign running   = (state == RUN);
  assign state_dbg = state;

  always_comb begin
    state_next    = state;
    q_next        = q;
    presc_next    = presc;
    done_next     = 1'b0;
    load_err_next = 1'b0;

    if (load) begin
      // A rejected load still wins the edge: nothing else moves this cycle.
      if (load_ok) begin
        q_next     = load_val;
        presc_next = '0;
        state_next = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && !zero) begin
            state_next = RUN;
            presc_next = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = HOLD;
          end else if (tick) begin
            presc_next = '0;
            if (!borrow[DIGITS]) begin
              q_next = q_dec;
              if (q_dec == '0) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
            end
          end else begin
            presc_next = presc + PW'(1);
          end
        end
        HOLD: begin
          // Prescaler is retained so a resumed run keeps its phase.
          if (start && !zero) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      presc    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      q        <= q_next;
      presc    <= presc_next;
      done     <= done_next;
      load_err <= load_err_next;
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT A: DIGITS=2, PRESCALE=1 ----------------
  logic       load_a = 1'b0, start_a = 1'b0;
  logic [7:0] val_a  = '0;
  logic [7:0] q_a;
  logic       run_a, zero_a, done_a, lerr_a;
  logic [1:0] st_a;

  bcd_down_timer #(.DIGITS(2), .PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset), .load(load_a), .load_val(val_a),
    .start(start_a), .pause(pause), .q(q_a), .running(run_a),
    .zero(zero_a), .done(done_a), .load_err(lerr_a), .state_dbg(st_a)
  );

  // ---------------- DUT B: DIGITS=2, PRESCALE=4 ----------------
  logic       load_b = 1'b0, start_b = 1'b0;
  logic [7:0] val_b  = '0;
  logic [7:0] q_b;
  logic       run_b, zero_b, done_b, lerr_b;
  logic [1:0] st_b;

  bcd_down_timer #(.DIGITS(2), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .load(load_b), .load_val(val_b),
    .start(start_b), .pause(1'b0), .q(q_b), .running(run_b),
    .zero(zero_b), .done(done_b), .load_err(lerr_b), .state_dbg(st_b)
  );

  // ---------------- DUT C: DIGITS=3, PRESCALE=1 ----------------
  logic        load_c = 1'b0, start_c = 1'b0;
  logic [11:0] val_c  = '0;
  logic [11:0] q_c;
  logic        run_c, zero_c, done_c, lerr_c;
  logic [1:0]  st_c;

  bcd_down_timer #(.DIGITS(3), .PRESCALE(1)) u_dut3 (
    .clk(clk), .reset(reset), .load(load_c), .load_val(val_c),
    .start(start_c), .pause(1'b0), .q(q_c), .running(run_c),
    .zero(zero_c), .done(done_c), .load_err(lerr_c), .state_dbg(st_c)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a_val(input logic [7:0] v);
    load_a = 1'b1;
    val_a  = v;
    step();
    load_a = 1'b0;
  endtask

  task automatic start_a_pulse();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    tests++; if (q_a !== 8'h00) begin fails++; $display("FAIL reset_q got %h exp 00", q_a); end
    tests++; if (zero_a !== 1'b1) begin fails++; $display("FAIL reset_zero got %b exp 1", zero_a); end
    tests++; if (run_a !== 1'b0 || done_a !== 1'b0 || lerr_a !== 1'b0) begin
      fails++; $display("FAIL reset_flags got run=%b done=%b lerr=%b exp 0 0 0", run_a, done_a, lerr_a);
    end
    tests++; if (st_a !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", st_a); end
    reset = 1'b0;
  endtask

  task automatic test_run_to_zero();
    logic [7:0] e;
    load_a_val(8'h12);
    tests++; if (q_a !== 8'h12) begin fails++; $display("FAIL run_load got %h exp 12", q_a); end
    start_a_pulse();
    tests++; if (run_a !== 1'b1 || q_a !== 8'h12) begin
      fails++; $display("FAIL run_start got run=%b q=%h exp run=1 q=12", run_a, q_a);
    end
    for (int n = 11; n >= 0; n--) begin
      step();
      e = 8'(((n / 10) * 16) + (n % 10));
      tests++; if (q_a !== e) begin fails++; $display("FAIL run_q got %h exp %h", q_a, e); end
      tests++; if (done_a !== (n == 0)) begin fails++; $display("FAIL run_done at %h got %b exp %b", e, done_a, (n == 0)); end
      tests++; if (run_a !== (n != 0)) begin fails++; $display("FAIL run_running at %h got %b exp %b", e, run_a, (n != 0)); end
    end
    step();
    tests++; if (q_a !== 8'h00 || done_a !== 1'b0) begin
      fails++; $display("FAIL run_after_zero got q=%h done=%b exp q=00 done=0", q_a, done_a);
    end
  endtask

  task automatic test_rejected_load();
    load_a_val(8'h45);
    tests++; if (q_a !== 8'h45 || lerr_a !== 1'b0) begin
      fails++; $display("FAIL rej_setup got q=%h lerr=%b exp q=45 lerr=0", q_a, lerr_a);
    end
    load_a_val(8'h3A);
    tests++; if (lerr_a !== 1'b1) begin fails++; $display("FAIL rej_lerr got %b exp 1", lerr_a); end
    tests++; if (q_a !== 8'h45) begin fails++; $display("FAIL rej_q got %h exp 45", q_a); end
    step();
    tests++; if (lerr_a !== 1'b0) begin fails++; $display("FAIL rej_pulse got %b exp 0", lerr_a); end
  endtask

  task automatic test_start_at_zero();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start_a_pulse();
    tests++; if (run_a !== 1'b0 || done_a !== 1'b0 || q_a !== 8'h00) begin
      fails++; $display("FAIL zstart got run=%b done=%b q=%h exp 0 0 00", run_a, done_a, q_a);
    end
    step();
    tests++; if (run_a !== 1'b0 || done_a !== 1'b0) begin
      fails++; $display("FAIL zstart_later got run=%b done=%b exp 0 0", run_a, done_a);
    end
  endtask

  task automatic test_pause_resume();
    load_a_val(8'h09);
    start_a_pulse();
    repeat (4) step();
    tests++; if (q_a !== 8'h05) begin fails++; $display("FAIL pause_pre got %h exp 05", q_a); end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (q_a !== 8'h05 || run_a !== 1'b0 || st_a !== 2'd2) begin
        fails++; $display("FAIL pause_hold got q=%h run=%b st=%0d exp q=05 run=0 st=2", q_a, run_a, st_a);
      end
    end
    pause = 1'b0;
    start_a_pulse();
    tests++; if (run_a !== 1'b1 || q_a !== 8'h05) begin
      fails++; $display("FAIL resume_start got run=%b q=%h exp run=1 q=05", run_a, q_a);
    end
    step();
    tests++; if (q_a !== 8'h04) begin fails++; $display("FAIL resume_dec got %h exp 04", q_a); end
    // Loading mid-run aborts without a done pulse.
    load_a_val(8'h00);
    tests++; if (run_a !== 1'b0 || done_a !== 1'b0 || q_a !== 8'h00) begin
      fails++; $display("FAIL abort got run=%b done=%b q=%h exp 0 0 00", run_a, done_a, q_a);
    end
  endtask

  task automatic test_reset_mid_run();
    load_a_val(8'h09);
    start_a_pulse();
    repeat (2) step();
    tests++; if (q_a !== 8'h07) begin fails++; $display("FAIL rstmid_pre got %h exp 07", q_a); end
    #2 reset = 1'b1;
    #1;
    tests++; if (q_a !== 8'h00 || zero_a !== 1'b1) begin
      fails++; $display("FAIL rstmid_async got q=%h zero=%b exp q=00 zero=1", q_a, zero_a);
    end
    tests++; if (done_a !== 1'b0 || run_a !== 1'b0) begin
      fails++; $display("FAIL rstmid_flags got done=%b run=%b exp 0 0", done_a, run_a);
    end
    reset = 1'b0;
    step();
    tests++; if (q_a !== 8'h00 || done_a !== 1'b0) begin
      fails++; $display("FAIL rstmid_after got q=%h done=%b exp 00 0", q_a, done_a);
    end
  endtask

  task automatic test_prescale();
    logic [7:0] e;
    load_b = 1'b1; val_b = 8'h03;
    step();
    load_b = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    tests++; if (run_b !== 1'b1 || q_b !== 8'h03) begin
      fails++; $display("FAIL ps_start got run=%b q=%h exp run=1 q=03", run_b, q_b);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      e = 8'(3 - (i / 4));
      tests++; if (q_b !== e) begin fails++; $display("FAIL ps_q at k+%0d got %h exp %h", i, q_b, e); end
      tests++; if (done_b !== (i == 12)) begin fails++; $display("FAIL ps_done at k+%0d got %b exp %b", i, done_b, (i == 12)); end
    end
    step();
    tests++; if (done_b !== 1'b0 || run_b !== 1'b0) begin
      fails++; $display("FAIL ps_end got done=%b run=%b exp 0 0", done_b, run_b);
    end
  endtask

  task automatic test_three_digit_borrow();
    load_c = 1'b1; val_c = 12'h100;
    step();
    load_c = 1'b0;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step();
    tests++; if (q_c !== 12'h099) begin fails++; $display("FAIL dig3_100 got %h exp 099", q_c); end
    step();
    tests++; if (q_c !== 12'h098) begin fails++; $display("FAIL dig3_099 got %h exp 098", q_c); end
    load_c = 1'b1; val_c = 12'h000;
    step();
    load_c = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_run_to_zero();
    test_rejected_load();
    test_start_at_zero();
    test_pause_resume();
    test_reset_mid_run();
    test_prescale();
    test_three_digit_borrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
